// File: rtl/seq_gates_rr_sched.sv
// seq_gates_rr_sched
//   Round-robin scheduler that shares one registered gate evaluator among
//   NREQ requesters. Each requester offers a 4-bit operand nibble. One
//   requester is granted per cycle. Its nibble and id are captured into a
//   single evaluator stage, and the stage returns
//   f = (~in0 | in1) & (in2 | ~in3) on a val/rdy response port.
//   A wrapping counter reports the number of completed responses.
//
// Ports
//   clk         in   1        clock, posedge
//   reset       in   1        asynchronous, active-high reset
//   req_val     in   NREQ     requester i offers a nibble
//   req_rdy     out  NREQ     requester i's nibble is taken this cycle
//   req_msg     in   4*NREQ   nibble i = req_msg[4i+3:4i], bit0=in0..bit3=in3
//   resp_val    out  1        evaluator stage holds a valid result
//   resp_rdy    in   1        consumer accepts the response
//   resp_id     out  IDW      requester that owns the result
//   resp_out    out  1        f of the captured nibble, 0 when idle
//   resp_count  out  CNTW     completed responses, wraps to 0
module seq_gates_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [4*NREQ-1:0] req_msg,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_out,
    output logic [CNTW-1:0]   resp_count
);

    logic [IDW-1:0]  r_ptr;
    logic            r_s1_val;
    logic [3:0]      r_s1_nib;
    logic [IDW-1:0]  r_s1_id;
    logic [CNTW-1:0] r_count;

    logic [NREQ-1:0] w_rot;
    logic            w_gnt_any;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_acc;
    logic            w_req_fire;
    logic            w_resp_fire;
    logic [3:0]      w_nib;

    // Rotate the request vector so bit 0 is the requester at ptr. The first
    // set bit is then the grant offset relative to ptr.
    assign w_rot = NREQ'({req_val, req_val} >> r_ptr);

    always_comb begin
        w_gnt_any = 1'b0;
        w_off     = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!w_gnt_any && w_rot[j]) begin
                w_gnt_any = 1'b1;
                w_off     = IDW'(j);
            end
        end
    end

    // Convert the offset back to an absolute id, modulo NREQ. NREQ need not
    // be a power of two.
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gnt_idx = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                 : w_sum[IDW-1:0];
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_acc       = ~r_s1_val | resp_rdy;
    // The reset term keeps req_rdy low while reset is held. The stage is
    // already empty during reset, so w_acc alone would not do this.
    assign w_req_fire  = w_gnt_any & w_acc & ~reset;
    assign w_resp_fire = r_s1_val & resp_rdy;

    // Only the granted slice is selected. Other requesters' nibbles never
    // reach the stage.
    assign w_nib = req_msg[4*w_gnt_idx +: 4];

    always_comb begin
        req_rdy = '0;
        if (w_req_fire) begin
            req_rdy[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_s1_val <= 1'b0;
            r_s1_nib <= '0;
            r_s1_id  <= '0;
            r_count  <= '0;
        end else begin
            if (w_req_fire) begin
                r_s1_val <= 1'b1;
                r_s1_nib <= w_nib;
                r_s1_id  <= w_gnt_idx;
                r_ptr    <= w_ptr_nxt;
            end else if (w_resp_fire) begin
                r_s1_val <= 1'b0;
            end
            if (w_resp_fire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign resp_val   = r_s1_val;
    assign resp_id    = r_s1_id;
    assign resp_out   = r_s1_val & ((~r_s1_nib[0] | r_s1_nib[1]) &
                                    (r_s1_nib[2] | ~r_s1_nib[3]));
    assign resp_count = r_count;

endmodule
